// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and its neighbours.
// - st_size_e   : store/load size encodings (SZ_B, SZ_H, SZ_W).
// - lane_word_t : byte-enable plus lane-aligned data for one word.
// - size_legal  : alignment/encoding legality of an access.
// - lane_align  : turns (size, addr[1:0], register value) into be + replicated data;
//                 the load-extension logic reuses the same lane mapping.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } st_size_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_word_t;

  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~addr_lo[0];
      SZ_W:    return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic lane_word_t lane_align(input logic [1:0]  size,
                                            input logic [1:0]  addr_lo,
                                            input logic [31:0] data);
    lane_word_t r;
    case (size)
      SZ_B: begin
        r.be   = 4'b0001 << addr_lo;
        r.data = {4{data[7:0]}};
      end
      SZ_H: begin
        r.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        r.data = {2{data[15:0]}};
      end
      default: begin
        r.be   = 4'b1111;
        r.data = data;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the M stage / data memory and the store buffer.
// - st_*  : store request (valid/ready handshake) and the illegal-store pulse.
// - ld_*  : M-stage load address and per-byte forwarding result.
// - dm_*  : data memory write port (dm_ready from memory, the rest to memory).
// master = pipeline/memory side, slave = store buffer.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        st_err;

  logic [31:0] ld_addr;
  logic [3:0]  ld_fwd_mask;
  logic [31:0] ld_fwd_word;

  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;

  modport master (
    output st_valid, st_addr, st_size, st_data, st_pc, ld_addr, dm_ready,
    input  st_ready, st_err, ld_fwd_mask, ld_fwd_word,
           dm_we, dm_addr, dm_be, dm_wdata, dm_pc
  );

  modport slave (
    input  st_valid, st_addr, st_size, st_data, st_pc, ld_addr, dm_ready,
    output st_ready, st_err, ld_fwd_mask, ld_fwd_word,
           dm_we, dm_addr, dm_be, dm_wdata, dm_pc
  );
endinterface

// File: rtl/store_buffer_fwd_lane.sv
// sb_fwd_lane: youngest-match select for one byte lane.
// - head       : index of the oldest entry.
// - hit        : per-entry match (valid, same word, lane enabled).
// - lane_bytes : per-entry byte for this lane.
// - fwd        : some pending entry covers this lane.
// - fwd_byte   : byte from the youngest covering entry, 0 when none.
module sb_fwd_lane #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]      head,
  input  logic [DEPTH-1:0]      hit,
  input  logic [DEPTH-1:0][7:0] lane_bytes,
  output logic                  fwd,
  output logic [7:0]            fwd_byte
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later hit overrides, so the youngest wins.
  always_comb begin
    fwd      = 1'b0;
    fwd_byte = 8'h00;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (hit[idx]) begin
        fwd      = 1'b1;
        fwd_byte = lane_bytes[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of lane-aligned stores between the M stage and data memory.
// - clk, reset : clock, synchronous active-high reset.
// - bus        : store request, load forwarding and data memory write port.
// - count      : occupancy; empty = (count == 0).
// Stores drain one per cycle from the head; loads see every queued byte,
// youngest store first, until the write has landed in memory.
module store_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  store_buffer_if.slave    bus,
  output logic [PTR_W:0]   count,
  output logic             empty
);
  import store_buffer_pkg::*;

  logic [29:0]      waddr_q [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic             err_p1;

  lane_word_t enc_p0;
  logic       legal_p0;
  logic       push;
  logic       pop;

  assign legal_p0 = size_legal(bus.st_size, bus.st_addr[1:0]);
  assign enc_p0   = lane_align(bus.st_size, bus.st_addr[1:0], bus.st_data);

  assign bus.dm_we    = (count_q != '0);
  assign pop          = bus.dm_we && bus.dm_ready;
  // A popping head frees its slot at the same edge, so a full queue still accepts.
  assign bus.st_ready = (count_q < (PTR_W+1)'(DEPTH)) || pop;
  assign push         = bus.st_valid && bus.st_ready && legal_p0;

  // ---- request -> queue (edge) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      err_p1  <= 1'b0;
    end else begin
      if (pop) begin
        head_q        <= head_q + PTR_W'(1);
        vld_q[head_q] <= 1'b0;
      end
      // Placed after the pop so a full-queue push into the freed slot stays valid.
      if (push) begin
        tail_q        <= tail_q + PTR_W'(1);
        vld_q[tail_q] <= 1'b1;
      end
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      err_p1  <= bus.st_valid && bus.st_ready && !legal_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= bus.st_addr[31:2];
      be_q[tail_q]    <= enc_p0.be;
      data_q[tail_q]  <= enc_p0.data;
      pc_q[tail_q]    <= bus.st_pc;
    end
  end

  // ---- queue -> memory / forwarding (combinational) ----
  assign bus.st_err   = err_p1;
  assign bus.dm_addr  = bus.dm_we ? {waddr_q[head_q], 2'b00} : 32'h0;
  assign bus.dm_be    = bus.dm_we ? be_q[head_q]   : 4'h0;
  assign bus.dm_wdata = bus.dm_we ? data_q[head_q] : 32'h0;
  assign bus.dm_pc    = bus.dm_we ? pc_q[head_q]   : 32'h0;
  assign count        = count_q;
  assign empty        = (count_q == '0);

  logic       fwd_hit  [4];
  logic [7:0] fwd_byte [4];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [DEPTH-1:0]      hit;
    logic [DEPTH-1:0][7:0] lb;

    always_comb begin
      hit = '0;
      lb  = '0;
      for (int e = 0; e < DEPTH; e++) begin
        hit[e] = vld_q[e] && (waddr_q[e] == bus.ld_addr[31:2]) && be_q[e][l];
        lb[e]  = data_q[e][8*l +: 8];
      end
    end

    sb_fwd_lane #(.DEPTH(DEPTH)) u_lane (
      .head       (head_q),
      .hit        (hit),
      .lane_bytes (lb),
      .fwd        (fwd_hit[l]),
      .fwd_byte   (fwd_byte[l])
    );
  end

  assign bus.ld_fwd_mask = {fwd_hit[3], fwd_hit[2], fwd_hit[1], fwd_hit[0]};
  assign bus.ld_fwd_word = {fwd_byte[3], fwd_byte[2], fwd_byte[1], fwd_byte[0]};

  // Loads are word-granular here; the byte offset is used by the consumer.
  logic unused_ld_lo;
  assign unused_ld_lo = ^bus.ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_store_buffer;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       empty;

  store_buffer_if sb_if();

  store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if.slave),
    .count (count),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   m_valid = 0;
  bit   m_err   = 0;

  function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 0;
    endcase
  endfunction

  function automatic ent_t m_enc(input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] d, input logic [31:0] pc);
    ent_t e;
    e.addr = a;
    e.pc   = pc;
    case (sz)
      2'd0:    begin e.be = 4'b0001 << a[1:0]; e.data = {4{d[7:0]}};  end
      2'd1:    begin e.be = 4'b0011 << a[1:0]; e.data = {2{d[15:0]}}; end
      default: begin e.be = 4'b1111;           e.data = d;            end
    endcase
    return e;
  endfunction

  logic        m_we, m_ready, m_pop, m_push;
  logic [3:0]  m_mask;
  logic [31:0] m_word;

  always @(negedge clk) begin
    m_we    = (mq.size() != 0);
    m_pop   = m_we && sb_if.dm_ready;
    m_ready = (mq.size() < 4) || m_pop;
    m_mask  = 4'h0;
    m_word  = 32'h0;
    foreach (mq[i]) begin
      if ((mq[i].addr >> 2) == (sb_if.ld_addr >> 2)) begin
        for (int l = 0; l < 4; l++) begin
          if (mq[i].be[l]) begin
            m_mask[l]       = 1'b1;
            m_word[8*l +: 8] = mq[i].data[8*l +: 8];
          end
        end
      end
    end
    if (m_valid) begin
      cmp("count",       32'(count),             32'(mq.size()));
      cmp("empty",       32'(empty),             32'(mq.size() == 0));
      cmp("st_ready",    32'(sb_if.st_ready),    32'(m_ready));
      cmp("st_err",      32'(sb_if.st_err),      32'(m_err));
      cmp("dm_we",       32'(sb_if.dm_we),       32'(m_we));
      cmp("dm_addr",     sb_if.dm_addr,          m_we ? (mq[0].addr & 32'hFFFF_FFFC) : 32'h0);
      cmp("dm_be",       32'(sb_if.dm_be),       m_we ? 32'(mq[0].be) : 32'h0);
      cmp("dm_wdata",    sb_if.dm_wdata,         m_we ? mq[0].data : 32'h0);
      cmp("dm_pc",       sb_if.dm_pc,            m_we ? mq[0].pc : 32'h0);
      cmp("ld_fwd_mask", 32'(sb_if.ld_fwd_mask), 32'(m_mask));
      cmp("ld_fwd_word", sb_if.ld_fwd_word,      m_word);
    end
    // advance the model to what the next edge must produce
    if (reset) begin
      mq.delete();
      m_err   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_push = sb_if.st_valid && m_ready && m_legal(sb_if.st_size, sb_if.st_addr);
      m_err  = sb_if.st_valid && m_ready && !m_legal(sb_if.st_size, sb_if.st_addr);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_enc(sb_if.st_addr, sb_if.st_size, sb_if.st_data, sb_if.st_pc));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] pc_n = 32'h0000_1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_size  = sz;
    sb_if.st_data  = d;
    sb_if.st_pc    = pc_n;
    pc_n           = pc_n + 32'd4;
    step();
    sb_if.st_valid = 1'b0;
  endtask

  task automatic bad_store(input logic [31:0] a, input logic [1:0] sz, input string nm);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_size  = sz;
    sb_if.st_data  = 32'h5555_5555;
    step();
    sb_if.st_valid = 1'b0;
    cmp({nm, "_err_pulse"}, 32'(sb_if.st_err), 32'h1);
    cmp({nm, "_count"},     32'(count),        32'h0);
    cmp({nm, "_no_we"},     32'(sb_if.dm_we),  32'h0);
    step();
    cmp({nm, "_err_clear"}, 32'(sb_if.st_err), 32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = 32'h0;
    sb_if.st_size  = 2'b00;
    sb_if.st_data  = 32'h0;
    sb_if.st_pc    = 32'h0;
    sb_if.ld_addr  = 32'h0;
    sb_if.dm_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    cmp("rst_count",    32'(count),             32'h0);
    cmp("rst_empty",    32'(empty),             32'h1);
    cmp("rst_ready",    32'(sb_if.st_ready),    32'h1);
    cmp("rst_we",       32'(sb_if.dm_we),       32'h0);
    cmp("rst_err",      32'(sb_if.st_err),      32'h0);
    cmp("rst_mask",     32'(sb_if.ld_fwd_mask), 32'h0);

    // single word store, memory always ready
    push(32'h0000_0010, 2'b10, 32'h1234_5678);
    cmp("sw_we",    32'(sb_if.dm_we), 32'h1);
    cmp("sw_addr",  sb_if.dm_addr,    32'h0000_0010);
    cmp("sw_be",    32'(sb_if.dm_be), 32'hF);
    cmp("sw_wdata", sb_if.dm_wdata,   32'h1234_5678);
    step();
    cmp("sw_empty", 32'(empty), 32'h1);

    // byte and half encodings
    push(32'h0000_0013, 2'b00, 32'h0000_00AB);
    cmp("sb_be",    32'(sb_if.dm_be), 32'h8);
    cmp("sb_wdata", sb_if.dm_wdata,   32'hABAB_ABAB);
    cmp("sb_addr",  sb_if.dm_addr,    32'h0000_0010);
    step();
    push(32'h0000_0022, 2'b01, 32'h0000_BEEF);
    cmp("sh_be",    32'(sb_if.dm_be), 32'hC);
    cmp("sh_hi",    32'(sb_if.dm_wdata[31:16]), 32'hBEEF);
    step();

    // fill, backpressure, full-queue push with simultaneous pop
    sb_if.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 2'b10, 32'hA000_0000 + 32'(i));
    cmp("full_count", 32'(count), 32'h4);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = 32'h110;
    sb_if.st_size  = 2'b10;
    sb_if.st_data  = 32'hA000_0004;
    sb_if.st_pc    = pc_n;
    pc_n           = pc_n + 32'd4;
    #1;
    cmp("full_not_ready", 32'(sb_if.st_ready), 32'h0);
    step();
    cmp("full_held_count", 32'(count),   32'h4);
    cmp("full_held_head",  sb_if.dm_addr, 32'h100);
    sb_if.dm_ready = 1'b1;
    #1;
    cmp("full_pop_ready", 32'(sb_if.st_ready), 32'h1);
    step();
    sb_if.st_valid = 1'b0;
    cmp("full_swap_count", 32'(count), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      cmp("drain_addr",  sb_if.dm_addr,  32'h100 + 32'(4*i));
      cmp("drain_wdata", sb_if.dm_wdata, 32'hA000_0000 + 32'(i));
      step();
    end
    cmp("drain_empty", 32'(empty), 32'h1);

    // forwarding merge
    sb_if.dm_ready = 1'b0;
    sb_if.ld_addr  = 32'h40;
    push(32'h40, 2'b10, 32'h1122_3344);
    push(32'h41, 2'b00, 32'h0000_0099);
    cmp("fwd_mask", 32'(sb_if.ld_fwd_mask), 32'hF);
    cmp("fwd_word", sb_if.ld_fwd_word,      32'h1122_9944);
    sb_if.ld_addr = 32'h44;
    #1;
    cmp("fwd_miss_mask", 32'(sb_if.ld_fwd_mask), 32'h0);
    cmp("fwd_miss_word", sb_if.ld_fwd_word,      32'h0);
    sb_if.ld_addr  = 32'h42;
    sb_if.dm_ready = 1'b1;
    #1;
    cmp("fwd_popping_head", 32'(sb_if.ld_fwd_mask), 32'hF);
    step();
    cmp("fwd_after_pop_mask", 32'(sb_if.ld_fwd_mask), 32'h2);
    cmp("fwd_after_pop_word", sb_if.ld_fwd_word,      32'h0000_9900);
    step();
    cmp("fwd_drained", 32'(empty), 32'h1);

    // illegal stores
    sb_if.dm_ready = 1'b0;
    bad_store(32'h21, 2'b01, "sh_mis");
    bad_store(32'h42, 2'b10, "sw_mis");
    bad_store(32'h50, 2'b11, "sz_ill");

    // reset in the middle of a backlog
    sb_if.ld_addr = 32'h64;
    push(32'h60, 2'b10, 32'h0101_0101);
    push(32'h64, 2'b10, 32'h0202_0202);
    push(32'h68, 2'b10, 32'h0303_0303);
    cmp("pre_rst_count", 32'(count),             32'h3);
    cmp("pre_rst_mask",  32'(sb_if.ld_fwd_mask), 32'hF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmp("mid_rst_count", 32'(count),             32'h0);
    cmp("mid_rst_we",    32'(sb_if.dm_we),       32'h0);
    cmp("mid_rst_mask",  32'(sb_if.ld_fwd_mask), 32'h0);
    cmp("mid_rst_ready", 32'(sb_if.st_ready),    32'h1);
    sb_if.dm_ready = 1'b1;
    push(32'h80, 2'b10, 32'hCAFE_F00D);
    cmp("post_rst_we",    32'(sb_if.dm_we), 32'h1);
    cmp("post_rst_addr",  sb_if.dm_addr,    32'h80);
    cmp("post_rst_wdata", sb_if.dm_wdata,   32'hCAFE_F00D);
    step();
    cmp("post_rst_empty", 32'(empty), 32'h1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
